// File: rtl/pe_dual_weight.sv
// rtl/pe_dual_weight.sv - weight-stationary systolic PE with double-buffered weights
// Shadow weight loads through a shift chain while active_w drives the MAC; SWAP_IN commits it.
module pe_dual_weight #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  CLK,
  input  logic                  ASYNC_RST,
  input  logic                  SYNC_RST,
  input  logic                  EN,
  input  logic                  SAT_EN,
  input  logic                  W_VALID_IN,
  input  logic [DATA_WIDTH-1:0] W_IN,
  output logic                  W_VALID_OUT,
  output logic [DATA_WIDTH-1:0] W_OUT,
  input  logic                  SWAP_IN,
  output logic                  SWAP_OUT,
  input  logic                  A_VALID_IN,
  input  logic [DATA_WIDTH-1:0] A_IN,
  output logic                  A_VALID_OUT,
  output logic [DATA_WIDTH-1:0] A_OUT,
  input  logic                  PSUM_VALID_IN,
  input  logic [ACC_WIDTH-1:0]  PSUM_IN,
  output logic                  PSUM_VALID_OUT,
  output logic [ACC_WIDTH-1:0]  PSUM_OUT,
  output logic                  OVF
);

  if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_width_check
    $error("pe_dual_weight: ACC_WIDTH must be >= 2*DATA_WIDTH");
  end

  logic [DATA_WIDTH-1:0]        shadow_w;
  logic                         shadow_full;
  logic [DATA_WIDTH-1:0]        active_w;

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH:0]      psum_term;
  logic signed [ACC_WIDTH:0]      wide_sum;
  logic                           ovf_now;
  logic [ACC_WIDTH-1:0]           sat_val;
  logic [ACC_WIDTH-1:0]           mac_result;

  // One extra bit of headroom lets overflow show up as a sign disagreement.
  always_comb begin
    prod       = $signed(A_IN) * $signed(active_w);
    psum_term  = PSUM_VALID_IN ? (ACC_WIDTH+1)'($signed(PSUM_IN)) : '0;
    wide_sum   = (ACC_WIDTH+1)'(prod) + psum_term;
    ovf_now    = wide_sum[ACC_WIDTH] ^ wide_sum[ACC_WIDTH-1];
    sat_val    = wide_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                     : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    mac_result = (ovf_now && SAT_EN) ? sat_val : wide_sum[ACC_WIDTH-1:0];
  end

  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      shadow_w       <= '0;
      shadow_full    <= 1'b0;
      active_w       <= '0;
      W_VALID_OUT    <= 1'b0;
      W_OUT          <= '0;
      SWAP_OUT       <= 1'b0;
      A_VALID_OUT    <= 1'b0;
      A_OUT          <= '0;
      PSUM_VALID_OUT <= 1'b0;
      PSUM_OUT       <= '0;
      OVF            <= 1'b0;
    end else if (SYNC_RST) begin
      shadow_w       <= '0;
      shadow_full    <= 1'b0;
      active_w       <= '0;
      W_VALID_OUT    <= 1'b0;
      W_OUT          <= '0;
      SWAP_OUT       <= 1'b0;
      A_VALID_OUT    <= 1'b0;
      A_OUT          <= '0;
      PSUM_VALID_OUT <= 1'b0;
      PSUM_OUT       <= '0;
      OVF            <= 1'b0;
    end else if (EN) begin
      SWAP_OUT    <= SWAP_IN;
      A_VALID_OUT <= A_VALID_IN;
      if (A_VALID_IN) A_OUT <= A_IN;

      // The word being displaced from the shadow travels on to the next PE.
      W_VALID_OUT <= W_VALID_IN & shadow_full;
      if (W_VALID_IN) begin
        W_OUT       <= shadow_w;
        shadow_w    <= W_IN;
        shadow_full <= 1'b1;
      end else if (SWAP_IN) begin
        shadow_full <= 1'b0;
      end
      if (SWAP_IN) active_w <= shadow_full ? shadow_w : '0;

      if (A_VALID_IN) begin
        PSUM_OUT       <= mac_result;
        PSUM_VALID_OUT <= 1'b1;
        if (ovf_now) OVF <= 1'b1;
      end else if (PSUM_VALID_IN) begin
        PSUM_OUT       <= PSUM_IN;
        PSUM_VALID_OUT <= 1'b1;
      end else begin
        PSUM_VALID_OUT <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_dual_weight.sv
// tb/tb_pe_dual_weight.sv - directed self-checking bench for pe_dual_weight
// Runs with ACC_WIDTH=16 so the saturation corners are reachable with 8-bit operands.
module tb_pe_dual_weight;

  localparam int DW = 8;
  localparam int AW = 16;

  logic          CLK = 1'b0;
  logic          ASYNC_RST, SYNC_RST, EN, SAT_EN;
  logic          W_VALID_IN, W_VALID_OUT, SWAP_IN, SWAP_OUT;
  logic [DW-1:0] W_IN, W_OUT, A_IN, A_OUT;
  logic          A_VALID_IN, A_VALID_OUT, PSUM_VALID_IN, PSUM_VALID_OUT, OVF;
  logic [AW-1:0] PSUM_IN, PSUM_OUT;

  int checks = 0;
  int errors = 0;

  pe_dual_weight #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .EN(EN), .SAT_EN(SAT_EN),
    .W_VALID_IN(W_VALID_IN), .W_IN(W_IN), .W_VALID_OUT(W_VALID_OUT), .W_OUT(W_OUT),
    .SWAP_IN(SWAP_IN), .SWAP_OUT(SWAP_OUT),
    .A_VALID_IN(A_VALID_IN), .A_IN(A_IN), .A_VALID_OUT(A_VALID_OUT), .A_OUT(A_OUT),
    .PSUM_VALID_IN(PSUM_VALID_IN), .PSUM_IN(PSUM_IN),
    .PSUM_VALID_OUT(PSUM_VALID_OUT), .PSUM_OUT(PSUM_OUT), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] pv(input int v);
    return v[AW-1:0];
  endfunction

  function automatic logic [DW-1:0] dv(input int v);
    return v[DW-1:0];
  endfunction

  initial begin
    ASYNC_RST = 1'b1; SYNC_RST = 1'b0; EN = 1'b1; SAT_EN = 1'b0;
    W_VALID_IN = 1'b0; W_IN = '0; SWAP_IN = 1'b0;
    A_VALID_IN = 1'b0; A_IN = '0; PSUM_VALID_IN = 1'b0; PSUM_IN = '0;

    // Asynchronous reset, checked before any clock edge
    #2 ASYNC_RST = 1'b0;
    #1;
    check("rst_psum", PSUM_OUT, 0);
    check("rst_pvalid", PSUM_VALID_OUT, 0);
    check("rst_avalid", A_VALID_OUT, 0);
    check("rst_wvalid", W_VALID_OUT, 0);
    check("rst_swap", SWAP_OUT, 0);
    check("rst_ovf", OVF, 0);
    tick();
    ASYNC_RST = 1'b1;
    tick();

    // active_w is zero after reset
    A_VALID_IN = 1'b1; A_IN = dv(5);
    tick();
    check("zero_w_psum", PSUM_OUT, 0);
    check("zero_w_pvalid", PSUM_VALID_OUT, 1);
    check("zero_w_aout", A_OUT, 5);
    check("zero_w_avalid", A_VALID_OUT, 1);

    // Load 3, swap, then -4*3+100
    A_VALID_IN = 1'b0; W_VALID_IN = 1'b1; W_IN = dv(3);
    tick();
    check("push3_wvalid", W_VALID_OUT, 0);
    check("idle_pvalid", PSUM_VALID_OUT, 0);
    check("idle_psum_hold", PSUM_OUT, 0);
    W_VALID_IN = 1'b0; SWAP_IN = 1'b1;
    tick();
    check("swap_out_hi", SWAP_OUT, 1);
    SWAP_IN = 1'b0; A_VALID_IN = 1'b1; A_IN = dv(-4); PSUM_VALID_IN = 1'b1; PSUM_IN = pv(100);
    tick();
    check("swap_out_lo", SWAP_OUT, 0);
    check("mac_88", PSUM_OUT, pv(88));

    // Shadow load during compute; a same-cycle swap still uses the old weight
    A_IN = dv(2); PSUM_VALID_IN = 1'b0; W_VALID_IN = 1'b1; W_IN = dv(7);
    tick();
    check("stream_w3_a", PSUM_OUT, pv(6));
    check("push7_wvalid", W_VALID_OUT, 0);
    W_VALID_IN = 1'b0; SWAP_IN = 1'b1;
    tick();
    check("stream_w3_swapcyc", PSUM_OUT, pv(6));
    SWAP_IN = 1'b0;
    tick();
    check("stream_w7", PSUM_OUT, pv(14));

    // Swap with an empty shadow commits zero
    A_VALID_IN = 1'b0; SWAP_IN = 1'b1;
    tick();
    SWAP_IN = 1'b0; A_VALID_IN = 1'b1; A_IN = dv(2);
    tick();
    check("empty_swap_psum", PSUM_OUT, 0);

    // Shift chain: 1,2,3 into an empty shadow
    A_VALID_IN = 1'b0;
    W_VALID_IN = 1'b1; W_IN = dv(1);
    tick();
    check("chain1_wvalid", W_VALID_OUT, 0);
    W_IN = dv(2);
    tick();
    check("chain2_wvalid", W_VALID_OUT, 1);
    check("chain2_wout", W_OUT, 1);
    W_IN = dv(3);
    tick();
    check("chain3_wvalid", W_VALID_OUT, 1);
    check("chain3_wout", W_OUT, 2);
    W_VALID_IN = 1'b0; SWAP_IN = 1'b1;
    tick();
    check("chain_idle_wvalid", W_VALID_OUT, 0);
    check("chain_idle_wout", W_OUT, 2);
    SWAP_IN = 1'b0; A_VALID_IN = 1'b1; A_IN = dv(4);
    tick();
    check("chain_shadow3", PSUM_OUT, pv(12));

    // Stall for 3 cycles with busy inputs
    EN = 1'b0; A_IN = dv(9); PSUM_VALID_IN = 1'b1; PSUM_IN = pv(500);
    SWAP_IN = 1'b1; W_VALID_IN = 1'b1; W_IN = dv(55);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_psum", PSUM_OUT, pv(12));
      check("stall_pvalid", PSUM_VALID_OUT, 1);
      check("stall_aout", A_OUT, 4);
      check("stall_swap", SWAP_OUT, 0);
      check("stall_wout", W_OUT, 2);
    end
    EN = 1'b1; SWAP_IN = 1'b0; W_VALID_IN = 1'b0;

    // Bubble pass-through
    A_VALID_IN = 1'b0; PSUM_IN = pv(42);
    tick();
    check("bubble_psum", PSUM_OUT, pv(42));
    check("bubble_pvalid", PSUM_VALID_OUT, 1);
    check("bubble_avalid", A_VALID_OUT, 0);
    check("bubble_aout_hold", A_OUT, 4);
    check("bubble_no_ovf", OVF, 0);

    // Saturation and wrap with weight 127
    PSUM_VALID_IN = 1'b0; W_VALID_IN = 1'b1; W_IN = dv(127);
    tick();
    W_VALID_IN = 1'b0; SWAP_IN = 1'b1;
    tick();
    SWAP_IN = 1'b0; SAT_EN = 1'b1;
    A_VALID_IN = 1'b1; A_IN = dv(127); PSUM_VALID_IN = 1'b1; PSUM_IN = pv(32767);
    tick();
    check("sat_pos", PSUM_OUT, pv(32767));
    check("sat_pos_ovf", OVF, 1);
    SAT_EN = 1'b0;
    tick();
    check("wrap_pos", PSUM_OUT, pv(127 * 127 + 32767));
    check("wrap_ovf", OVF, 1);
    SAT_EN = 1'b1; A_IN = dv(-128); PSUM_IN = pv(-32768);
    tick();
    check("sat_neg", PSUM_OUT, pv(-32768));
    A_IN = dv(1); PSUM_IN = pv(5);
    tick();
    check("ovf_sticky", OVF, 1);
    check("no_ovf_sum", PSUM_OUT, pv(132));

    // SYNC_RST wins over EN=0
    EN = 1'b0; SYNC_RST = 1'b1;
    tick();
    check("srst_ovf", OVF, 0);
    check("srst_psum", PSUM_OUT, 0);
    check("srst_avalid", A_VALID_OUT, 0);
    EN = 1'b1; SYNC_RST = 1'b0; PSUM_VALID_IN = 1'b0; A_IN = dv(5);
    tick();
    check("srst_active_zero", PSUM_OUT, 0);

    // Asynchronous reset mid-stream drops valids immediately
    #2 ASYNC_RST = 1'b0;
    #1;
    check("arst_mid_pvalid", PSUM_VALID_OUT, 0);
    check("arst_mid_avalid", A_VALID_OUT, 0);
    tick();
    ASYNC_RST = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
